// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory bus endpoint.
package slc3_mem_pkg;

  localparam int unsigned MEM_W            = 16;
  localparam int unsigned MEM_CNT_W        = 4;
  localparam int unsigned MEM_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: clears to zero, counts while enabled, flags the last strobe cycle.
module mem_wait_counter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [MEM_CNT_W-1:0] count_q;

  // Count register; clear wins over enable so a new access always starts at zero.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + MEM_CNT_W'(1);
    end
  end

  // Terminal count marks the final cycle the strobes are held.
  always_comb begin
    tc = (count_q == MEM_CNT_W'(WAIT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus endpoint: holds MAR/MDR and runs fixed-length SRAM accesses.
module mem_bus_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [MEM_W-1:0] DataBus,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             MIO_EN,
  input  logic             R_W,
  input  logic             GateMDR,
  output logic             R,
  output logic [MEM_W-1:0] MAR,
  output logic [MEM_W-1:0] MDR,
  output logic [MEM_W-1:0] Bus_MDR,
  output logic [MEM_W-1:0] Mem_ADDR,
  output logic             Mem_CE_N,
  output logic             Mem_OE_N,
  output logic             Mem_WE_N,
  input  logic [MEM_W-1:0] Mem_Data_In,
  output logic [MEM_W-1:0] Mem_Data_Out,
  output logic             Mem_Data_OE
);

  // The 4-bit counter cannot express longer waits; refuse to build rather than wrap.
  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_wait_range_error
    $error("mem_bus_ctrl: WAIT_CYCLES must be within 1..15");
  end

  mem_state_t       state_q, state_d;
  logic             wr_q;
  logic [MEM_W-1:0] mar_q;
  logic [MEM_W-1:0] mdr_q;
  logic             tc;
  logic             in_access;

  assign in_access = (state_q == ACCESS);

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (~in_access),
    .en    (in_access),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a started access always runs to terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (MIO_EN) state_d = ACCESS;
      ACCESS:  if (tc)     state_d = DONE;
      DONE:    if (!MIO_EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and ready decode, purely from registered state and latched access type.
  always_comb begin
    R           = 1'b0;
    Mem_CE_N    = 1'b1;
    Mem_OE_N    = 1'b1;
    Mem_WE_N    = 1'b1;
    Mem_Data_OE = 1'b0;
    unique case (state_q)
      ACCESS: begin
        Mem_CE_N    = 1'b0;
        Mem_OE_N    = wr_q;
        Mem_WE_N    = ~wr_q;
        Mem_Data_OE = wr_q;
      end
      DONE:    R = 1'b1;
      default: ;
    endcase
  end

  // MAR/MDR and access type; bus loads are locked out while the SRAM is being strobed.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mar_q <= '0;
      mdr_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      if (!in_access) begin
        if (LD_MAR) mar_q <= DataBus;
        if (LD_MDR && !MIO_EN) mdr_q <= DataBus;
      end
      if ((state_q == IDLE) && MIO_EN) wr_q <= R_W;
      // Read data is captured on the same edge that moves to DONE.
      if (in_access && tc && !wr_q) mdr_q <= Mem_Data_In;
    end
  end

  // Register views and datapath bus driver.
  always_comb begin
    MAR          = mar_q;
    MDR          = mdr_q;
    Mem_ADDR     = mar_q;
    Mem_Data_Out = mdr_q;
    Bus_MDR      = GateMDR ? mdr_q : '0;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance.
module tb_mem_bus_ctrl;
  import slc3_mem_pkg::*;

  localparam int unsigned W = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset;
  logic [15:0] DataBus;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W, GateMDR;
  logic        R;
  logic [15:0] MAR, MDR, Bus_MDR, Mem_ADDR, Mem_Data_In, Mem_Data_Out;
  logic        Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Data_OE;

  logic [15:0] d1_DataBus;
  logic        d1_LD_MAR, d1_MIO_EN;
  logic        d1_R;
  logic [15:0] d1_MAR, d1_MDR, d1_Bus_MDR, d1_ADDR, d1_Data_In, d1_Data_Out;
  logic        d1_CE_N, d1_OE_N, d1_WE_N, d1_Data_OE;

  mem_bus_ctrl #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .Reset(Reset), .DataBus(DataBus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .GateMDR(GateMDR), .R(R), .MAR(MAR), .MDR(MDR),
    .Bus_MDR(Bus_MDR), .Mem_ADDR(Mem_ADDR), .Mem_CE_N(Mem_CE_N), .Mem_OE_N(Mem_OE_N),
    .Mem_WE_N(Mem_WE_N), .Mem_Data_In(Mem_Data_In), .Mem_Data_Out(Mem_Data_Out),
    .Mem_Data_OE(Mem_Data_OE)
  );

  mem_bus_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .DataBus(d1_DataBus), .LD_MAR(d1_LD_MAR), .LD_MDR(1'b0),
    .MIO_EN(d1_MIO_EN), .R_W(1'b0), .GateMDR(1'b1), .R(d1_R), .MAR(d1_MAR), .MDR(d1_MDR),
    .Bus_MDR(d1_Bus_MDR), .Mem_ADDR(d1_ADDR), .Mem_CE_N(d1_CE_N), .Mem_OE_N(d1_OE_N),
    .Mem_WE_N(d1_WE_N), .Mem_Data_In(d1_Data_In), .Mem_Data_Out(d1_Data_Out),
    .Mem_Data_OE(d1_Data_OE)
  );

  // SRAM models
  logic [15:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_a, pl_d;
  assign Mem_Data_In = (!Mem_CE_N && !Mem_OE_N) ? mem[Mem_ADDR] : 16'h0000;
  always @(posedge CLK) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!Mem_CE_N && !Mem_WE_N && Mem_Data_OE) mem[Mem_ADDR] <= Mem_Data_Out;
  end

  logic [15:0] mem1 [0:255];
  initial begin
    mem1[0] = 16'h1111;
    mem1[1] = 16'h2222;
  end
  assign d1_Data_In = (!d1_CE_N && !d1_OE_N) ? mem1[d1_ADDR[7:0]] : 16'h0000;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned rise;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the WAIT_CYCLES=2 instance
  exp_t        e;
  int unsigned burst = 0;
  logic        r_prev = 1'b0;
  always @(negedge CLK) begin
    if (Reset) begin
      burst  = 0;
      r_prev = 1'b0;
    end else begin
      if (!Mem_CE_N) begin
        if (sb.size() == 0) begin
          check("unexpected_access", 32'd1, 32'd0);
        end else begin
          check("addr", Mem_ADDR, sb[0].addr);
          check("oe_n", Mem_OE_N, sb[0].wr);
          check("we_n", Mem_WE_N, !sb[0].wr);
          check("data_oe", Mem_Data_OE, sb[0].wr);
          if (sb[0].wr) check("wdata", Mem_Data_Out, sb[0].data);
          burst++;
        end
      end else begin
        check("idle_strobes", {Mem_OE_N, Mem_WE_N, Mem_Data_OE}, 3'b110);
      end
      if (R && !r_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ready_cycle", cyc, e.rise);
          check("burst_len", burst, W);
          check("mdr", MDR, e.data);
          check("bus_mdr", Bus_MDR, GateMDR ? e.data : 16'h0000);
          if (e.wr) check("sram_word", mem[e.addr], e.data);
        end
        burst = 0;
      end
      r_prev = R;
    end
  end

  // Monitor for the WAIT_CYCLES=1 instance
  exp_t        e1;
  int unsigned burst1 = 0;
  logic        r1_prev = 1'b0;
  always @(negedge CLK) begin
    if (Reset) begin
      burst1  = 0;
      r1_prev = 1'b0;
    end else begin
      if (!d1_CE_N) begin
        check("w1_strobes", {d1_OE_N, d1_WE_N, d1_Data_OE}, 3'b010);
        burst1++;
      end
      if (d1_R && !r1_prev) begin
        if (sb1.size() == 0) begin
          check("w1_unexpected_ready", 32'd1, 32'd0);
        end else begin
          e1 = sb1.pop_front();
          check("w1_ready_cycle", cyc, e1.rise);
          check("w1_burst_len", burst1, 32'd1);
          check("w1_mdr", d1_MDR, e1.data);
          check("w1_bus_mdr", d1_Bus_MDR, e1.data);
          check("w1_data_out", d1_Data_Out, e1.data);
          check("w1_mar", d1_MAR, e1.addr);
        end
        burst1 = 0;
      end
      r1_prev = d1_R;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic load_mar(input logic [15:0] a);
    DataBus = a; LD_MAR = 1'b1;
    tick();
    LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] d);
    DataBus = d; LD_MDR = 1'b1;
    tick();
    LD_MDR = 1'b0;
  endtask

  // One access on the W=2 instance; optional hold of MIO_EN in DONE and mid-access disturbance
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                           input int hold, input bit disturb);
    sb.push_back('{wr, addr, data, cyc + 1 + W});
    MIO_EN = 1'b1; R_W = wr;
    tick();
    if (disturb) begin
      R_W = !wr; LD_MAR = 1'b1; LD_MDR = 1'b1; DataBus = 16'hFFFF;
    end
    for (int i = 0; i < 20 && !R; i++) tick();
    check("ready_seen", R, 1'b1);
    LD_MAR = 1'b0; LD_MDR = 1'b0; R_W = wr;
    repeat (hold) begin
      tick();
      check("ready_held", R, 1'b1);
    end
    MIO_EN = 1'b0;
    tick();
    check("ready_fall", R, 1'b0);
    check("state_idle", dut.state_q, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; DataBus = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0; GateMDR = 0;
    d1_DataBus = '0; d1_LD_MAR = 0; d1_MIO_EN = 0;
    pl_en = 0; pl_a = '0; pl_d = '0;
    preload(16'h3000, 16'hBEEF);
    preload(16'h0020, 16'h1234);
    tick();
    check("rst_mar", MAR, 16'h0000);
    check("rst_mdr", MDR, 16'h0000);
    check("rst_r", R, 1'b0);
    check("rst_strobes", {Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Data_OE}, 4'b1110);
    check("rst_state", dut.state_q, IDLE);
    Reset = 1'b0;
    tick();

    // Read 0x3000 -> 0xBEEF
    load_mar(16'h3000);
    GateMDR = 1'b1;
    do_access(1'b0, 16'h3000, 16'hBEEF, 0, 1'b0);
    check("bus_mdr_gated", Bus_MDR, 16'hBEEF);
    GateMDR = 1'b0;
    #1;
    check("bus_mdr_ungated", Bus_MDR, 16'h0000);

    // Write 0x8001 to 0x0010
    load_mar(16'h0010);
    load_mdr(16'h8001);
    do_access(1'b1, 16'h0010, 16'h8001, 0, 1'b0);
    check("mdr_after_write", MDR, 16'h8001);
    check("sram_0010", mem[16'h0010], 16'h8001);

    // Held request: one burst only
    load_mar(16'h3000);
    do_access(1'b0, 16'h3000, 16'hBEEF, 5, 1'b0);

    // Disturbance during a read and during a write
    load_mar(16'h0020);
    do_access(1'b0, 16'h0020, 16'h1234, 0, 1'b1);
    check("dist_rd_mar", MAR, 16'h0020);
    check("dist_rd_mdr", MDR, 16'h1234);
    load_mar(16'h0030);
    load_mdr(16'h5A5A);
    do_access(1'b1, 16'h0030, 16'h5A5A, 0, 1'b1);
    check("dist_wr_mar", MAR, 16'h0030);
    check("dist_wr_sram", mem[16'h0030], 16'h5A5A);

    // Reset in the second strobe cycle of a write
    load_mar(16'h0040);
    load_mdr(16'h7777);
    sb.push_back('{1'b1, 16'h0040, 16'h7777, cyc + 1 + W});
    MIO_EN = 1'b1; R_W = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("midrst_strobes", {Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Data_OE}, 4'b1110);
    check("midrst_mar", MAR, 16'h0000);
    check("midrst_mdr", MDR, 16'h0000);
    check("midrst_r", R, 1'b0);
    check("midrst_state", dut.state_q, IDLE);
    sb.delete();
    Reset = 1'b0; MIO_EN = 1'b0; R_W = 1'b0;
    tick();
    check("post_rst_r", R, 1'b0);

    // WAIT_CYCLES=1: two reads separated by one idle cycle
    d1_DataBus = 16'h0100; d1_LD_MAR = 1'b1;
    tick();
    d1_LD_MAR = 1'b0;
    sb1.push_back('{1'b0, 16'h0100, 16'h1111, cyc + 2});
    d1_MIO_EN = 1'b1;
    tick();
    for (int i = 0; i < 20 && !d1_R; i++) tick();
    check("w1_ready_seen_a", d1_R, 1'b1);
    d1_MIO_EN = 1'b0; d1_DataBus = 16'h0101; d1_LD_MAR = 1'b1;
    tick();
    d1_LD_MAR = 1'b0;
    check("w1_ready_fall", d1_R, 1'b0);
    sb1.push_back('{1'b0, 16'h0101, 16'h2222, cyc + 2});
    d1_MIO_EN = 1'b1;
    tick();
    for (int i = 0; i < 20 && !d1_R; i++) tick();
    check("w1_ready_seen_b", d1_R, 1'b1);
    d1_MIO_EN = 1'b0;
    tick();
    tick();
    check("sb_drained", sb.size() + sb1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
